// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single data DRAM port between the CPU pipeline
// (port C) and a secondary master such as a loader or DMA engine (port D).
// The CPU has fixed priority. A DMA request that keeps losing wins once it
// has waited STARVE_LIMIT cycles. The DMA can lock the port for bursts.
// Read data returns one cycle after the grant and is steered back to the
// port that issued the read.
// Optional build macro DRAM_ARB_STATS_EN adds 32-bit grant/conflict counters.
module dram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdin,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdo,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_op,
  input  logic [ADDR_W-1:0] dma_adr,
  input  logic [DATA_W-1:0] dma_wdin,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdo,
  // DRAM side
  output logic [ADDR_W-1:0] dram_adr,
  output logic [1:0]        dram_w_op,
  output logic              dram_we,
  output logic [DATA_W-1:0] dram_wdin,
  input  logic [DATA_W-1:0] dram_rdo
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_cpu_gnt,
  output logic [31:0]       stat_dma_gnt,
  output logic [31:0]       stat_conflict
`endif
);

  typedef enum logic {
    IDLE     = 1'b0,
    DMA_LOCK = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [1:0] rd_pend;     // one-hot {dma, cpu}: read issued last cycle
  logic       starved;

  assign starved = (starve_cnt >= LIMIT);

  // Per-cycle arbitration: lock owner first, then CPU priority with the
  // starvation override for a DMA request that has waited too long.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/else leaves it unassigned and infers a latch.
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst) begin
      if (state == DMA_LOCK) begin
        dma_gnt = dma_req;
      end else if (cpu_req && dma_req) begin
        if (starved) dma_gnt = 1'b1;
        else         cpu_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Steer the granted port onto the DRAM; drive zeros when nobody owns it.
  always_comb begin
    dram_adr  = '0;
    dram_w_op = '0;
    dram_we   = 1'b0;
    dram_wdin = '0;
    if (cpu_gnt) begin
      dram_adr  = cpu_adr;
      dram_w_op = cpu_op;
      dram_we   = cpu_we;
      dram_wdin = cpu_wdin;
    end else if (dma_gnt) begin
      dram_adr  = dma_adr;
      dram_w_op = dma_op;
      dram_we   = dma_we;
      dram_wdin = dma_wdin;
    end
  end

  // Read return: the DRAM answers one cycle after the address, so the
  // pending bit from last cycle selects which port sees the data.
  assign cpu_rvalid = rd_pend[0] & ~rst;
  assign dma_rvalid = rd_pend[1] & ~rst;
  assign cpu_rdo    = cpu_rvalid ? dram_rdo : '0;
  assign dma_rdo    = dma_rvalid ? dram_rdo : '0;

  // Lock state, starvation counter and read-pending tracking.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rd_pend    <= '0;
    end else begin
      case (state)
        IDLE:     if (dma_gnt && dma_lock) state <= DMA_LOCK;
        DMA_LOCK: if (!dma_lock)           state <= IDLE;
        default:                           state <= IDLE;
      endcase

      if (dma_gnt || !dma_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      rd_pend <= {dma_gnt & ~dma_we, cpu_gnt & ~cpu_we};
    end
  end

`ifdef DRAM_ARB_STATS_EN
  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cpu_gnt  <= '0;
      stat_dma_gnt  <= '0;
      stat_conflict <= '0;
    end else begin
      if (cpu_gnt)            stat_cpu_gnt  <= stat_cpu_gnt + 32'd1;
      if (dma_gnt)            stat_dma_gnt  <= stat_dma_gnt + 32'd1;
      if (cpu_req && dma_req) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule
